// File: rtl/ssi_mtx.sv
// ============================================================================
// ssi_mtx -- multi-lane synchronous-serial transmitter (fabric -> ARM SSI)
//
// Buffers parallel sample words in a FIFO, then shifts each word MSB-first on
// NUM_LANE lanes in parallel. Each frame is a one-bit frame-sync period
// (fss=1, data=0), WORD_W data bits, and GAP_BITS idle bit periods with
// ssi_clk held low. Data and fss change on ssi_clk falling edges; the ARM
// samples on rising edges.
//
// Optional feature (macro SSI_PARITY_EN): when defined, each lane sends one
// extra bit after bit 0 carrying odd parity of that lane's WORD_W bits.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en            transmit enable (checked only between frames)
//   din_valid/din write strobe and word; lane i = din[i*WORD_W +: WORD_W]
//   din_ready     FIFO not full (registered)
//   ovf_clr       clears the sticky overflow flag
//   overflow      sticky; set when a write was dropped
//   fifo_usedw    FIFO occupancy (registered)
//   busy          FSM not idle (registered)
//   ssi_clk/ssi_fss/ssi_xdat  serial clock, frame sync, data lanes
// ============================================================================
module ssi_mtx #(
    parameter int NUM_LANE   = 4,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 2,
    parameter int GAP_BITS   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          din_valid,
    input  logic [NUM_LANE*WORD_W-1:0]    din,
    output logic                          din_ready,
    input  logic                          ovf_clr,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_usedw,
    output logic                          busy,
    output logic                          ssi_clk,
    output logic                          ssi_fss,
    output logic [NUM_LANE-1:0]           ssi_xdat
);
    localparam int DW = NUM_LANE * WORD_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef SSI_PARITY_EN
    localparam int SHIFT_BITS = WORD_W + 1;
`else
    localparam int SHIFT_BITS = WORD_W;
`endif
    localparam int BW = $clog2(SHIFT_BITS + GAP_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] SHIFT_LAST = BW'(SHIFT_BITS - 1);
    localparam logic [BW-1:0] GAP_LAST   = BW'(GAP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t                             state_q, state_d;
    logic [TW-1:0]                      tick_q, tick_d;
    logic                               phase_q, phase_d;   // internal half-bit phase
    logic [BW-1:0]                      bit_q, bit_d;
    logic [NUM_LANE-1:0][WORD_W-1:0]    shreg_q, shreg_d;
    logic                               fss_q, fss_d;
    logic [NUM_LANE-1:0]                xdat_q, xdat_d;
    logic                               sclk_q, sclk_d;
    logic                               busy_q, busy_d;
    logic [AW-1:0]                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic                               ready_q, ready_d;
    logic                               ovf_q, ovf_d;
`ifdef SSI_PARITY_EN
    localparam logic [BW-1:0] PAR_IDX = BW'(WORD_W - 1);
    logic [NUM_LANE-1:0]                par_q, par_d, head_par;
`endif

    // FIFO storage; head is read directly so LOAD can capture it on the pop edge
    logic [DW-1:0]                      mem_q [FIFO_DEPTH];
    logic [DW-1:0]                      head;
    logic [NUM_LANE-1:0][WORD_W-1:0]    head_lanes;
    logic                               wr_en, pop, start, next_frame, emit;
    logic                               tick_wrap, bit_end, can_start;

    assign head = mem_q[rd_ptr_q];

    for (genvar gi = 0; gi < NUM_LANE; gi++) begin : g_lane
        assign head_lanes[gi] = head[gi*WORD_W +: WORD_W];
`ifdef SSI_PARITY_EN
        assign head_par[gi] = ~^head_lanes[gi];
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        fss_d      = fss_q;
        xdat_d     = xdat_q;
`ifdef SSI_PARITY_EN
        par_d      = par_q;
`endif
        start      = 1'b0;
        next_frame = 1'b0;
        emit       = 1'b0;
        tick_wrap  = (tick_q == TICK_LAST);
        bit_end    = tick_wrap && phase_q;
        can_start  = en && (cnt_q != '0);

        if (state_q != S_IDLE) begin
            tick_d = tick_wrap ? '0 : tick_q + TW'(1);
            if (tick_wrap) begin
                phase_d = ~phase_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                fss_d  = 1'b0;
                xdat_d = '0;
                start  = can_start;
            end
            S_LOAD: begin
                if (bit_end) begin
                    state_d = S_SHIFT;
                    bit_d   = '0;
                    fss_d   = 1'b0;
                    emit    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_end) begin
                    if (bit_q == SHIFT_LAST) begin
                        if (GAP_BITS > 0) begin
                            state_d = S_GAP;
                            bit_d   = '0;
                            xdat_d  = '0;
                        end else begin
                            next_frame = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                        emit  = 1'b1;
                    end
                end
            end
            default: begin  // S_GAP
                if (bit_end) begin
                    if (bit_q == GAP_LAST) begin
                        next_frame = 1'b1;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
        endcase

        // Put the current MSB of every lane on the wire and advance the shifters
        if (emit) begin
            for (int i = 0; i < NUM_LANE; i++) begin
                xdat_d[i]  = shreg_q[i][WORD_W-1];
                shreg_d[i] = shreg_q[i] << 1;
            end
`ifdef SSI_PARITY_EN
            if (state_q == S_SHIFT && bit_q == PAR_IDX) begin
                xdat_d = par_q;
            end
`endif
        end

        // End of frame: chain straight into the next LOAD when possible
        if (next_frame) begin
            if (can_start) begin
                start = 1'b1;
            end else begin
                state_d = S_IDLE;
                fss_d   = 1'b0;
                xdat_d  = '0;
                tick_d  = '0;
                phase_d = 1'b0;
            end
        end

        if (start) begin
            state_d = S_LOAD;
            tick_d  = '0;
            phase_d = 1'b0;
            fss_d   = 1'b1;
            xdat_d  = '0;
            shreg_d = head_lanes;
`ifdef SSI_PARITY_EN
            par_d   = head_par;
`endif
        end
        pop = start;

        // ssi_clk follows the phase only while bits are being clocked out
        sclk_d = (state_d == S_LOAD || state_d == S_SHIFT) ? phase_d : 1'b0;
        busy_d = (state_d != S_IDLE);

        // FIFO bookkeeping; a write into a full FIFO is accepted if a pop frees the slot
        wr_en    = din_valid && ((cnt_q != FULL_CNT) || pop);
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (wr_en ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
        ready_d  = (cnt_d != FULL_CNT);
        // A dropped write wins over a simultaneous clear
        if (din_valid && !wr_en) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            phase_q  <= 1'b0;
            bit_q    <= '0;
            shreg_q  <= '0;
            fss_q    <= 1'b0;
            xdat_q   <= '0;
            sclk_q   <= 1'b0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef SSI_PARITY_EN
            par_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            fss_q    <= fss_d;
            xdat_q   <= xdat_d;
            sclk_q   <= sclk_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
`ifdef SSI_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign din_ready  = ready_q;
    assign overflow   = ovf_q;
    assign fifo_usedw = cnt_q;
    assign busy       = busy_q;
    assign ssi_clk    = sclk_q;
    assign ssi_fss    = fss_q;
    assign ssi_xdat   = xdat_q;
endmodule

// File: tb/tb_ssi_mtx.sv
`timescale 1ns/1ps
module tb_ssi_mtx;
    localparam int NUM_LANE   = 4;
    localparam int WORD_W     = 32;
    localparam int FIFO_DEPTH = 16;
    localparam int CLK_DIV    = 2;
    localparam int GAP_BITS   = 2;
    localparam int DW         = NUM_LANE * WORD_W;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
`ifdef SSI_PARITY_EN
    localparam int SHIFT_BITS = WORD_W + 1;
`else
    localparam int SHIFT_BITS = WORD_W;
`endif
    localparam int BIT_CLK   = 2 * CLK_DIV;
    localparam int FRAME_CLK = BIT_CLK * (1 + SHIFT_BITS + GAP_BITS);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 din_valid = 1'b0;
    logic [DW-1:0]        din = '0;
    logic                 din_ready;
    logic                 ovf_clr = 1'b0;
    logic                 overflow;
    logic [CW-1:0]        fifo_usedw;
    logic                 busy;
    logic                 ssi_clk;
    logic                 ssi_fss;
    logic [NUM_LANE-1:0]  ssi_xdat;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ssi_mtx #(
        .NUM_LANE(NUM_LANE), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH),
        .CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
        .din_ready(din_ready), .ovf_clr(ovf_clr), .overflow(overflow),
        .fifo_usedw(fifo_usedw), .busy(busy), .ssi_clk(ssi_clk),
        .ssi_fss(ssi_fss), .ssi_xdat(ssi_xdat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and monitor records
    logic [DW-1:0]       exp_q[$];
    logic [DW-1:0]       rx_q[$];
    logic [NUM_LANE-1:0] rx_par_q[$];
    int                  fss_rise_q[$];
    int                  fss_fall_q[$];
    int                  busy_fall_q[$];
    logic [CW-1:0]       usedw_at_fss_q[$];
    int                  sclk_rises = 0;

    logic          prev_sclk = 1'b0, prev_fss = 1'b0, prev_busy = 1'b0;
    logic          collecting = 1'b0;
    int            bitn = 0;
    logic [DW-1:0] acc = '0;

    // Deserialiser: samples lanes on ssi_clk rising edges, away from clk edges
    always @(negedge clk) begin
        if (rst) begin
            collecting = 1'b0;
        end else begin
            if (ssi_clk && !prev_sclk) begin
                sclk_rises++;
                if (ssi_fss) begin
                    collecting = 1'b1;
                    bitn = 0;
                    acc = '0;
                end else if (collecting) begin
                    if (bitn < WORD_W) begin
                        for (int l = 0; l < NUM_LANE; l++)
                            acc[l*WORD_W + (WORD_W-1-bitn)] = ssi_xdat[l];
                        bitn++;
                        if (bitn == SHIFT_BITS) begin
                            rx_q.push_back(acc);
                            rx_par_q.push_back('0);
                            collecting = 1'b0;
                        end
                    end else begin
                        rx_q.push_back(acc);
                        rx_par_q.push_back(ssi_xdat);
                        collecting = 1'b0;
                    end
                end
            end
            if (ssi_fss && !prev_fss) begin
                fss_rise_q.push_back(cyc);
                usedw_at_fss_q.push_back(fifo_usedw);
            end
            if (!ssi_fss && prev_fss) fss_fall_q.push_back(cyc);
            if (!busy && prev_busy) busy_fall_q.push_back(cyc);
        end
        prev_sclk = ssi_clk;
        prev_fss  = ssi_fss;
        prev_busy = busy;
    end

    task automatic clear_mon();
        exp_q.delete(); rx_q.delete(); rx_par_q.delete();
        fss_rise_q.delete(); fss_fall_q.delete(); busy_fall_q.delete();
        usedw_at_fss_q.delete();
        sclk_rises = 0;
    endtask

    // Presents one word for one clk; the bench decides whether it is expected to be kept
    task automatic write_word(input logic [DW-1:0] w, input bit keep);
        din = w;
        din_valid = 1'b1;
        if (keep) exp_q.push_back(w);
        @(posedge clk); #1;
        din_valid = 1'b0;
        din = '0;
    endtask

    task automatic wait_busy_falls(input int n, input int budget);
        for (int k = 0; k < budget && busy_fall_q.size() < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_fss_rises(input int n, input int budget);
        for (int k = 0; k < budget && fss_rise_q.size() < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready got=%b want=1", din_ready); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        checks++; if (fifo_usedw !== '0) begin failures++; $display("FAIL reset_usedw got=%0d want=0", fifo_usedw); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (ssi_clk !== 1'b0) begin failures++; $display("FAIL reset_ssi_clk got=%b want=0", ssi_clk); end
        checks++; if (ssi_fss !== 1'b0) begin failures++; $display("FAIL reset_ssi_fss got=%b want=0", ssi_fss); end
        checks++; if (ssi_xdat !== '0) begin failures++; $display("FAIL reset_ssi_xdat got=%h want=0", ssi_xdat); end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        int t;
        int f;
        logic [DW-1:0] w;
        clear_mon();
        en = 1'b1;
        w = 128'h80000001_00000000_FFFFFFFF_A5A5A5A5;
        t = cyc;
        write_word(w, 1'b1);
        wait_busy_falls(1, FRAME_CLK + 50);
        checks++;
        if (fss_rise_q.size() != 1 || fss_fall_q.size() != 1 || busy_fall_q.size() != 1) begin
            failures++;
            $display("FAIL single_events fss_rises=%0d fss_falls=%0d busy_falls=%0d want=1,1,1",
                     fss_rise_q.size(), fss_fall_q.size(), busy_fall_q.size());
        end else begin
            f = fss_rise_q[0];
            checks++; if (f !== t + 2) begin failures++; $display("FAIL single_fss_latency got=%0d want=%0d", f - t, 2); end
            checks++; if (fss_fall_q[0] - f !== BIT_CLK) begin failures++; $display("FAIL single_fss_width got=%0d want=%0d", fss_fall_q[0] - f, BIT_CLK); end
            checks++; if (busy_fall_q[0] - f !== FRAME_CLK) begin failures++; $display("FAIL single_busy_drop got=%0d want=%0d", busy_fall_q[0] - f, FRAME_CLK); end
        end
        checks++; if (sclk_rises !== 1 + SHIFT_BITS) begin failures++; $display("FAIL single_sclk_edges got=%0d want=%0d", sclk_rises, 1 + SHIFT_BITS); end
        checks++;
        if (rx_q.size() != 1) begin
            failures++; $display("FAIL single_rx_count got=%0d want=1", rx_q.size());
        end else if (rx_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL single_data got=%h want=%h", rx_q[0], exp_q[0]);
        end
        en = 1'b0;
        $display("test_single done fss_rises=%0d rx=%0d", fss_rise_q.size(), rx_q.size());
    endtask

    task automatic test_back_to_back();
        int t;
        clear_mon();
        en = 1'b1;
        t = cyc;
        for (int i = 0; i < 3; i++) write_word({$urandom, $urandom, $urandom, 32'(i + 100)}, 1'b1);
        wait_busy_falls(1, 3 * FRAME_CLK + 100);
        checks++;
        if (fss_rise_q.size() != 3 || busy_fall_q.size() != 1) begin
            failures++;
            $display("FAIL b2b_events fss_rises=%0d busy_falls=%0d want=3,1", fss_rise_q.size(), busy_fall_q.size());
        end else begin
            checks++; if (fss_rise_q[0] !== t + 2) begin failures++; $display("FAIL b2b_first_fss got=%0d want=2", fss_rise_q[0] - t); end
            checks++; if (fss_rise_q[1] - fss_rise_q[0] !== FRAME_CLK) begin failures++; $display("FAIL b2b_spacing1 got=%0d want=%0d", fss_rise_q[1] - fss_rise_q[0], FRAME_CLK); end
            checks++; if (fss_rise_q[2] - fss_rise_q[1] !== FRAME_CLK) begin failures++; $display("FAIL b2b_spacing2 got=%0d want=%0d", fss_rise_q[2] - fss_rise_q[1], FRAME_CLK); end
            checks++; if (usedw_at_fss_q[1] !== CW'(1)) begin failures++; $display("FAIL b2b_usedw2 got=%0d want=1", usedw_at_fss_q[1]); end
            checks++; if (usedw_at_fss_q[2] !== CW'(0)) begin failures++; $display("FAIL b2b_usedw3 got=%0d want=0", usedw_at_fss_q[2]); end
            checks++; if (busy_fall_q[0] - fss_rise_q[2] !== FRAME_CLK) begin failures++; $display("FAIL b2b_busy_drop got=%0d want=%0d", busy_fall_q[0] - fss_rise_q[2], FRAME_CLK); end
        end
        checks++;
        if (rx_q.size() != 3) begin
            failures++; $display("FAIL b2b_rx_count got=%0d want=3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_data%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
            end
        end
        en = 1'b0;
        $display("test_back_to_back done fss_rises=%0d rx=%0d", fss_rise_q.size(), rx_q.size());
    endtask

    task automatic test_overflow();
        clear_mon();
        en = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++)
            write_word({$urandom, $urandom, $urandom, 32'(i + 1)}, i < FIFO_DEPTH);
        checks++; if (fifo_usedw !== CW'(FIFO_DEPTH)) begin failures++; $display("FAIL ovf_usedw got=%0d want=%0d", fifo_usedw, FIFO_DEPTH); end
        checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL ovf_din_ready got=%b want=0", din_ready); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovf_busy_while_disabled got=%b want=0", busy); end
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", overflow); end
        en = 1'b1;
        wait_busy_falls(1, FIFO_DEPTH * FRAME_CLK + 200);
        checks++;
        if (rx_q.size() != FIFO_DEPTH) begin
            failures++; $display("FAIL ovf_rx_count got=%0d want=%0d", rx_q.size(), FIFO_DEPTH);
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_data%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
            end
        end
        checks++; if (fifo_usedw !== '0) begin failures++; $display("FAIL ovf_drained got=%0d want=0", fifo_usedw); end
        en = 1'b0;
        $display("test_overflow done rx=%0d", rx_q.size());
    endtask

    task automatic test_en_drop();
        int f;
        int t;
        clear_mon();
        en = 1'b1;
        write_word({32'h11111111, 32'h22222222, 32'h33333333, 32'h00000001}, 1'b1);
        write_word({32'h44444444, 32'h55555555, 32'h66666666, 32'h00000002}, 1'b1);
        wait_fss_rises(1, 20);
        checks++;
        if (fss_rise_q.size() != 1) begin
            failures++; $display("FAIL endrop_start got=%0d fss rises want=1", fss_rise_q.size());
        end else begin
            f = fss_rise_q[0];
            while (cyc < f + BIT_CLK + 10 * BIT_CLK) begin @(posedge clk); #1; end
            en = 1'b0;
            wait_busy_falls(1, FRAME_CLK + 50);
            checks++;
            if (busy_fall_q.size() != 1) begin
                failures++; $display("FAIL endrop_idle got=%0d busy falls want=1", busy_fall_q.size());
            end else begin
                checks++; if (busy_fall_q[0] - f !== FRAME_CLK) begin failures++; $display("FAIL endrop_frame_len got=%0d want=%0d", busy_fall_q[0] - f, FRAME_CLK); end
            end
            checks++; if (fifo_usedw !== CW'(1)) begin failures++; $display("FAIL endrop_usedw got=%0d want=1", fifo_usedw); end
            repeat (5) @(posedge clk);
            #1;
            checks++; if (busy !== 1'b0 || fss_rise_q.size() != 1) begin failures++; $display("FAIL endrop_stays_idle busy=%b fss_rises=%0d want=0,1", busy, fss_rise_q.size()); end
            t = cyc;
            en = 1'b1;
            wait_busy_falls(2, FRAME_CLK + 50);
            checks++;
            if (fss_rise_q.size() != 2) begin
                failures++; $display("FAIL endrop_restart got=%0d fss rises want=2", fss_rise_q.size());
            end else begin
                checks++; if (fss_rise_q[1] - t !== 1) begin failures++; $display("FAIL endrop_restart_latency got=%0d want=1", fss_rise_q[1] - t); end
            end
        end
        checks++;
        if (rx_q.size() != 2) begin
            failures++; $display("FAIL endrop_rx_count got=%0d want=2", rx_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL endrop_data%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
            end
        end
        en = 1'b0;
        $display("test_en_drop done rx=%0d", rx_q.size());
    endtask

    task automatic test_reset_mid();
        int f;
        int n0;
        clear_mon();
        en = 1'b1;
        write_word({32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0}, 1'b1);
        write_word({32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00FF00FF, 32'hFF00FF00}, 1'b1);
        wait_fss_rises(1, 20);
        checks++;
        if (fss_rise_q.size() != 1) begin
            failures++; $display("FAIL rstmid_start got=%0d fss rises want=1", fss_rise_q.size());
        end else begin
            f = fss_rise_q[0];
            while (cyc < f + BIT_CLK + 20 * BIT_CLK) begin @(posedge clk); #1; end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (ssi_clk !== 1'b0) begin failures++; $display("FAIL rstmid_ssi_clk got=%b want=0", ssi_clk); end
        checks++; if (ssi_fss !== 1'b0) begin failures++; $display("FAIL rstmid_ssi_fss got=%b want=0", ssi_fss); end
        checks++; if (ssi_xdat !== '0) begin failures++; $display("FAIL rstmid_ssi_xdat got=%h want=0", ssi_xdat); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (fifo_usedw !== '0) begin failures++; $display("FAIL rstmid_usedw got=%0d want=0", fifo_usedw); end
        checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL rstmid_din_ready got=%b want=1", din_ready); end
        rst = 1'b0;
        exp_q.delete();
        n0 = sclk_rises;
        repeat (300) @(posedge clk);
        #1;
        checks++; if (sclk_rises !== n0) begin failures++; $display("FAIL rstmid_sclk_quiet got=%0d edges want=0", sclk_rises - n0); end
        checks++; if (busy !== 1'b0 || rx_q.size() != 0) begin failures++; $display("FAIL rstmid_no_frame busy=%b rx=%0d want=0,0", busy, rx_q.size()); end
        en = 1'b0;
        $display("test_reset_mid done sclk_edges_after=%0d", sclk_rises - n0);
    endtask

`ifdef SSI_PARITY_EN
    task automatic test_parity();
        clear_mon();
        en = 1'b1;
        write_word({96'h0, 32'h00000001}, 1'b1);
        write_word({96'h0, 32'h00000000}, 1'b1);
        wait_busy_falls(1, 2 * FRAME_CLK + 50);
        checks++;
        if (fss_rise_q.size() != 2 || rx_q.size() != 2) begin
            failures++; $display("FAIL par_events fss_rises=%0d rx=%0d want=2,2", fss_rise_q.size(), rx_q.size());
        end else begin
            checks++; if (fss_rise_q[1] - fss_rise_q[0] !== 144) begin failures++; $display("FAIL par_frame_len got=%0d want=144", fss_rise_q[1] - fss_rise_q[0]); end
            checks++; if (rx_par_q[0] !== 4'b1110) begin failures++; $display("FAIL par_word1 got=%b want=1110", rx_par_q[0]); end
            checks++; if (rx_par_q[1] !== 4'b1111) begin failures++; $display("FAIL par_word2 got=%b want=1111", rx_par_q[1]); end
            checks++; if (rx_q[0] !== exp_q[0]) begin failures++; $display("FAIL par_data got=%h want=%h", rx_q[0], exp_q[0]); end
        end
        en = 1'b0;
        $display("test_parity done rx=%0d", rx_q.size());
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_en_drop();
        test_reset_mid();
`ifdef SSI_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
